alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
- Parametrised execute-stage unit for the MIPS pipeline; successor to the single-cycle ALU.
- Executes all `EXE_*_OP` ALU operations from defines2.vh combinationally.
- Adds owned HI/LO registers and an iterative multi-cycle MULT/MULTU/DIV/DIVU engine with a stall handshake to the pipeline controller.
- Sits in EX; result_o feeds the EX/MEM register.

Parameters:
- WIDTH, 32, datapath width in bits (power of two, ≥8).
- SHW, 5, shift-amount width; must equal log2(WIDTH).
- OPW, 8, opcode width (matches the `EXE_*_OP` encoding).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- valid_i  in  1  EX stage holds a live instruction.
- flush_i  in  1  EX flush (exception or branch kill); aborts any mul/div.
- op_i  in  OPW  `EXE_*_OP` code.
- a_i  in  WIDTH  rs operand.
- b_i  in  WIDTH  rt operand or extended immediate.
- sa_i  in  SHW  shamt field.
- result_o  out  WIDTH  ALU result (combinational).
- zero_o  out  1  result_o == 0.
- overflow_o  out  1  signed overflow; ADD/ADDI/SUB only.
- stall_o  out  1  mul/div in progress; pipeline holds EX inputs stable.
- hi_o  out  WIDTH  current HI register.
- lo_o  out  WIDTH  current LO register.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, HI=LO=0, counter=0, stall_o=0. Combinational outputs follow their inputs.
- Combinational ops: logic, shifts and arithmetic as per the ISA.
  - ANDI/ORI/XORI zero-extend b_i[15:0]; LUI gives {b_i[15:0], zeros}.
  - SRA/SRAV are arithmetic shifts. Variable shifts use a_i[SHW-1:0].
  - SLT/SLTI compare signed; SLTU/SLTIU compare unsigned. Result is 1 or 0 in the LSB, upper bits zero.
  - Loads and stores output a_i+b_i.
  - MFHI/MFLO return HI/LO. MTHI/MTLO output a_i.
  - Unknown op gives 0.
- Overflow: computed at WIDTH+1 bits with double sign bit. overflow_o = ext[WIDTH] ^ ext[WIDTH-1] for ADD/ADDI/SUB; 0 for all other ops.
- MTHI/MTLO write HI/LO at the clock edge when valid_i=1, flush_i=0 and stall_o=0.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: if valid_i & ~flush_i & op is a mul/div op, latch |a|, |b|, signs and signedness. Clear counter. Go to MUL or DIV.
  - MUL: radix-2 shift-add, one bit per cycle. Leave after WIDTH cycles (counter==WIDTH-1) to DONE.
  - DIV: restoring, one quotient bit per cycle, WIDTH cycles, then DONE.
  - DONE: apply sign correction and write {HI,LO}; return to IDLE.
- stall_o = valid_i & mul/div op & state!=DONE (combinational).
  - stall_o is high from the issue cycle through the last iteration.
  - Total occupancy is WIDTH+2 cycles with stall_o high for WIDTH+1 of them (34/33 at WIDTH=32).
  - The HI/LO write is visible to an MFHI in the following cycle.
- Sign rules:
  - MULT gives the signed 2*WIDTH product.
  - DIV: quotient sign = sa^sb; remainder takes the dividend's sign. LO=quotient, HI=remainder.
  - Unsigned variants skip correction.
  - Most-negative / -1 yields LO=most-negative, HI=0, with no trap.
- Divide by zero: no trap. Unsigned gives LO=all-ones, HI=dividend. Signed gives the natural restoring result after sign correction.
- flush_i: in any state, forces IDLE the next edge. No HI/LO write; stall_o drops combinationally.
- op_i change while busy is a pipeline protocol violation; the latched operands are used regardless.

Optional Feature:
- Macro: ALU_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle `*` multiplier registered into DONE. IDLE→DONE→IDLE, stall_o high for 1 cycle, 2 cycles total.
- DIV is unchanged.
- Undefined: iterative multiply as specified above.

Test Plan:
- ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, overflow_o=1.
- ADDU with the same operands -> overflow_o=0.
- SRA b=0xF0000000, sa=4 -> 0xFF000000.
- SLT a=0xFFFFFFFF, b=1 -> 1.
- SLTU with the same operands -> 0.
- MULT a=-3, b=7 -> stall_o high 33 cycles. HI=0xFFFFFFFF, LO=0xFFFFFFEB. The next-cycle MFHI/MFLO return these values.
- DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU a=100, b=0 -> LO=0xFFFFFFFF, HI=100.
- Start DIVU, assert flush_i on cycle 10 -> stall_o=0 next cycle, HI/LO unchanged. Same test with rst pulsed mid-MUL -> HI=LO=0, state IDLE.
- MTHI 0x12345678, then immediately MFHI -> 0x12345678.
- With ALU_FAST_MUL_EN defined: MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE, stall_o high for exactly 1 cycle.

Source files
------------

// File: rtl/alu_muldiv.sv
// Execute-stage ALU with owned HI/LO and an iterative MULT/MULTU/DIV/DIVU engine.
// Optional macro ALU_FAST_MUL_EN: single-cycle multiplier registered straight into DONE.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter int OPW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             flush_i,
    input  logic [OPW-1:0]   op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   sa_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam logic [OPW-1:0] EXE_AND_OP   = OPW'(8'b00100100);
    localparam logic [OPW-1:0] EXE_OR_OP    = OPW'(8'b00100101);
    localparam logic [OPW-1:0] EXE_XOR_OP   = OPW'(8'b00100110);
    localparam logic [OPW-1:0] EXE_NOR_OP   = OPW'(8'b00100111);
    localparam logic [OPW-1:0] EXE_ANDI_OP  = OPW'(8'b01011001);
    localparam logic [OPW-1:0] EXE_ORI_OP   = OPW'(8'b01011010);
    localparam logic [OPW-1:0] EXE_XORI_OP  = OPW'(8'b01011011);
    localparam logic [OPW-1:0] EXE_LUI_OP   = OPW'(8'b01011100);
    localparam logic [OPW-1:0] EXE_SLL_OP   = OPW'(8'b01111100);
    localparam logic [OPW-1:0] EXE_SLLV_OP  = OPW'(8'b00000100);
    localparam logic [OPW-1:0] EXE_SRL_OP   = OPW'(8'b00000010);
    localparam logic [OPW-1:0] EXE_SRLV_OP  = OPW'(8'b00000110);
    localparam logic [OPW-1:0] EXE_SRA_OP   = OPW'(8'b00000011);
    localparam logic [OPW-1:0] EXE_SRAV_OP  = OPW'(8'b00000111);
    localparam logic [OPW-1:0] EXE_MFHI_OP  = OPW'(8'b00010000);
    localparam logic [OPW-1:0] EXE_MTHI_OP  = OPW'(8'b00010001);
    localparam logic [OPW-1:0] EXE_MFLO_OP  = OPW'(8'b00010010);
    localparam logic [OPW-1:0] EXE_MTLO_OP  = OPW'(8'b00010011);
    localparam logic [OPW-1:0] EXE_SLT_OP   = OPW'(8'b00101010);
    localparam logic [OPW-1:0] EXE_SLTU_OP  = OPW'(8'b00101011);
    localparam logic [OPW-1:0] EXE_SLTI_OP  = OPW'(8'b01010111);
    localparam logic [OPW-1:0] EXE_SLTIU_OP = OPW'(8'b01011000);
    localparam logic [OPW-1:0] EXE_ADD_OP   = OPW'(8'b00100000);
    localparam logic [OPW-1:0] EXE_ADDU_OP  = OPW'(8'b00100001);
    localparam logic [OPW-1:0] EXE_SUB_OP   = OPW'(8'b00100010);
    localparam logic [OPW-1:0] EXE_SUBU_OP  = OPW'(8'b00100011);
    localparam logic [OPW-1:0] EXE_ADDI_OP  = OPW'(8'b01010101);
    localparam logic [OPW-1:0] EXE_ADDIU_OP = OPW'(8'b01010110);
    localparam logic [OPW-1:0] EXE_MULT_OP  = OPW'(8'b00011000);
    localparam logic [OPW-1:0] EXE_MULTU_OP = OPW'(8'b00011001);
    localparam logic [OPW-1:0] EXE_DIV_OP   = OPW'(8'b00011010);
    localparam logic [OPW-1:0] EXE_DIVU_OP  = OPW'(8'b00011011);
    localparam logic [OPW-1:0] EXE_LB_OP    = OPW'(8'b11100000);
    localparam logic [OPW-1:0] EXE_LBU_OP   = OPW'(8'b11100100);
    localparam logic [OPW-1:0] EXE_LH_OP    = OPW'(8'b11100001);
    localparam logic [OPW-1:0] EXE_LHU_OP   = OPW'(8'b11100101);
    localparam logic [OPW-1:0] EXE_LW_OP    = OPW'(8'b11100011);
    localparam logic [OPW-1:0] EXE_SB_OP    = OPW'(8'b11101000);
    localparam logic [OPW-1:0] EXE_SH_OP    = OPW'(8'b11101001);
    localparam logic [OPW-1:0] EXE_SW_OP    = OPW'(8'b11101011);

    // Immediate field is 16 bits, clipped for narrow datapaths.
    localparam int IMW = (WIDTH < 16) ? WIDTH : 16;
    localparam logic [WIDTH-1:0] IMM_MASK = {WIDTH{1'b1}} >> (WIDTH - IMW);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic neg);
        abs_val = neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t               state_r;
    logic [WIDTH-1:0]     hi_r, lo_r, opnd_r;
    logic [2*WIDTH-1:0]   work_r;
    logic [SHW-1:0]       cnt_r;
    logic                 sgn_a_r, sgn_b_r, is_mul_r;

    logic                 is_mul_s, is_div_s, is_sgnd_s, muldiv_s;
    logic                 neg_a_s, neg_b_s;
    logic [WIDTH-1:0]     abs_a_s, abs_b_s, zext_s, result_s;
    logic [WIDTH:0]       add_ext_s, sub_ext_s, mul_sum_s, div_shift_s;
    logic [WIDTH-1:0]     div_diff_s, quo_fix_s, rem_fix_s;
    logic                 div_ge_s, overflow_s;
    logic [2*WIDTH-1:0]   prod_fix_s;

    assign is_mul_s  = (op_i == EXE_MULT_OP) | (op_i == EXE_MULTU_OP);
    assign is_div_s  = (op_i == EXE_DIV_OP)  | (op_i == EXE_DIVU_OP);
    assign is_sgnd_s = (op_i == EXE_MULT_OP) | (op_i == EXE_DIV_OP);
    assign muldiv_s  = is_mul_s | is_div_s;
    assign neg_a_s   = is_sgnd_s & a_i[WIDTH-1];
    assign neg_b_s   = is_sgnd_s & b_i[WIDTH-1];
    assign abs_a_s   = abs_val(a_i, neg_a_s);
    assign abs_b_s   = abs_val(b_i, neg_b_s);
    assign zext_s    = b_i & IMM_MASK;

    // Double-sign-bit arithmetic exposes signed overflow as ext[W] ^ ext[W-1].
    assign add_ext_s = {a_i[WIDTH-1], a_i} + {b_i[WIDTH-1], b_i};
    assign sub_ext_s = {a_i[WIDTH-1], a_i} - {b_i[WIDTH-1], b_i};

    // Iteration datapath: work_r holds {partial, multiplier} or {remainder, quotient}.
    assign mul_sum_s   = {1'b0, work_r[2*WIDTH-1:WIDTH]}
                       + (work_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    assign div_shift_s = {work_r[2*WIDTH-1:WIDTH], work_r[WIDTH-1]};
    assign div_ge_s    = div_shift_s >= {1'b0, opnd_r};
    assign div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;

    assign prod_fix_s = (sgn_a_r ^ sgn_b_r) ? (~work_r + {{(2*WIDTH-1){1'b0}}, 1'b1}) : work_r;
    assign quo_fix_s  = abs_val(work_r[WIDTH-1:0], sgn_a_r ^ sgn_b_r);
    assign rem_fix_s  = abs_val(work_r[2*WIDTH-1:WIDTH], sgn_a_r);

    assign stall_o = valid_i & ~flush_i & muldiv_s & (state_r != DONE);

    // Combinational ALU result and overflow selection.
    always_comb begin
        result_s   = {WIDTH{1'b0}};
        overflow_s = 1'b0;
        case (op_i)
            EXE_AND_OP:   result_s = a_i & b_i;
            EXE_OR_OP:    result_s = a_i | b_i;
            EXE_XOR_OP:   result_s = a_i ^ b_i;
            EXE_NOR_OP:   result_s = ~(a_i | b_i);
            EXE_ANDI_OP:  result_s = a_i & zext_s;
            EXE_ORI_OP:   result_s = a_i | zext_s;
            EXE_XORI_OP:  result_s = a_i ^ zext_s;
            EXE_LUI_OP:   result_s = b_i << (WIDTH - IMW);
            EXE_SLL_OP:   result_s = b_i << sa_i;
            EXE_SLLV_OP:  result_s = b_i << a_i[SHW-1:0];
            EXE_SRL_OP:   result_s = b_i >> sa_i;
            EXE_SRLV_OP:  result_s = b_i >> a_i[SHW-1:0];
            EXE_SRA_OP:   result_s = $signed(b_i) >>> sa_i;
            EXE_SRAV_OP:  result_s = $signed(b_i) >>> a_i[SHW-1:0];
            EXE_MFHI_OP:  result_s = hi_r;
            EXE_MFLO_OP:  result_s = lo_r;
            EXE_MTHI_OP, EXE_MTLO_OP: result_s = a_i;
            EXE_SLT_OP, EXE_SLTI_OP:
                result_s = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            EXE_SLTU_OP, EXE_SLTIU_OP:
                result_s = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            EXE_ADD_OP, EXE_ADDI_OP: begin
                result_s   = add_ext_s[WIDTH-1:0];
                overflow_s = add_ext_s[WIDTH] ^ add_ext_s[WIDTH-1];
            end
            EXE_SUB_OP: begin
                result_s   = sub_ext_s[WIDTH-1:0];
                overflow_s = sub_ext_s[WIDTH] ^ sub_ext_s[WIDTH-1];
            end
            EXE_ADDU_OP, EXE_ADDIU_OP: result_s = add_ext_s[WIDTH-1:0];
            EXE_SUBU_OP:  result_s = sub_ext_s[WIDTH-1:0];
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP:
                result_s = add_ext_s[WIDTH-1:0];
            default:      result_s = {WIDTH{1'b0}};
        endcase
    end

    assign result_o   = result_s;
    assign zero_o     = (result_s == {WIDTH{1'b0}});
    assign overflow_o = overflow_s;
    assign hi_o       = hi_r;
    assign lo_o       = lo_r;

    // Mul/div sequencer plus HI/LO ownership.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            opnd_r   <= {WIDTH{1'b0}};
            work_r   <= {(2*WIDTH){1'b0}};
            cnt_r    <= {SHW{1'b0}};
            sgn_a_r  <= 1'b0;
            sgn_b_r  <= 1'b0;
            is_mul_r <= 1'b0;
        end else if (flush_i) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_i && muldiv_s) begin
                        sgn_a_r  <= neg_a_s;
                        sgn_b_r  <= neg_b_s;
                        is_mul_r <= is_mul_s;
                        cnt_r    <= {SHW{1'b0}};
                        if (is_mul_s) begin
`ifdef ALU_FAST_MUL_EN
                            work_r  <= {{WIDTH{1'b0}}, abs_a_s} * {{WIDTH{1'b0}}, abs_b_s};
                            state_r <= DONE;
`else
                            opnd_r  <= abs_a_s;
                            work_r  <= {{WIDTH{1'b0}}, abs_b_s};
                            state_r <= MUL;
`endif
                        end else begin
                            opnd_r  <= abs_b_s;
                            work_r  <= {{WIDTH{1'b0}}, abs_a_s};
                            state_r <= DIV;
                        end
                    end else if (valid_i && (op_i == EXE_MTHI_OP)) begin
                        hi_r <= a_i;
                    end else if (valid_i && (op_i == EXE_MTLO_OP)) begin
                        lo_r <= a_i;
                    end
                end
                MUL: begin
                    work_r <= {mul_sum_s, work_r[WIDTH-1:1]};
                    cnt_r  <= cnt_r + SHW'(1);
                    if (cnt_r == SHW'(WIDTH - 1)) begin
                        state_r <= DONE;
                    end
                end
                DIV: begin
                    work_r <= div_ge_s ? {div_diff_s, work_r[WIDTH-2:0], 1'b1}
                                       : {div_shift_s[WIDTH-1:0], work_r[WIDTH-2:0], 1'b0};
                    cnt_r  <= cnt_r + SHW'(1);
                    if (cnt_r == SHW'(WIDTH - 1)) begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (is_mul_r) begin
                        {hi_r, lo_r} <= prod_fix_s;
                    end else begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end
                    state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: stimulus queues expectations, a negedge monitor retires them.
module tb_alu_muldiv;

    localparam logic [7:0] OP_AND = 8'b00100100, OP_NOR = 8'b00100111, OP_ANDI = 8'b01011001;
    localparam logic [7:0] OP_LUI = 8'b01011100, OP_SLLV = 8'b00000100, OP_SRL = 8'b00000010;
    localparam logic [7:0] OP_SRA = 8'b00000011, OP_MFHI = 8'b00010000, OP_MTHI = 8'b00010001;
    localparam logic [7:0] OP_MFLO = 8'b00010010, OP_MTLO = 8'b00010011, OP_SLT = 8'b00101010;
    localparam logic [7:0] OP_SLTU = 8'b00101011, OP_ADD = 8'b00100000, OP_ADDU = 8'b00100001;
    localparam logic [7:0] OP_SUB = 8'b00100010, OP_ADDI = 8'b01010101, OP_MULT = 8'b00011000;
    localparam logic [7:0] OP_MULTU = 8'b00011001, OP_DIV = 8'b00011010, OP_DIVU = 8'b00011011;
    localparam logic [7:0] OP_LW = 8'b11100011, OP_BAD = 8'b11111111;

`ifdef ALU_FAST_MUL_EN
    localparam int MSTALL = 1;
`else
    localparam int MSTALL = 33;
`endif
    localparam int DSTALL = 33;

    logic        clk, rst, valid_i, flush_i;
    logic [7:0]  op_i;
    logic [31:0] a_i, b_i;
    logic [4:0]  sa_i;
    logic [31:0] result_o, hi_o, lo_o;
    logic        zero_o, overflow_o, stall_o;

    alu_muldiv #(.WIDTH(32), .SHW(5), .OPW(8)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .flush_i(flush_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .sa_i(sa_i), .result_o(result_o), .zero_o(zero_o),
        .overflow_o(overflow_o), .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        bit          chk_res;
        logic [31:0] res;
        logic        ovf;
        int          stalls;
        bit          chk_hl;
        logic [31:0] hi;
        logic [31:0] lo;
    } item_t;

    item_t sb[$];
    int    total = 0;
    int    bad   = 0;
    bit    end_req = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: counts stall cycles and retires one expectation per completed instruction.
    initial begin : monitor
        int    stall_run;
        item_t it;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (rst || flush_i) begin
                stall_run = 0;
            end else if (valid_i && stall_o) begin
                stall_run++;
                if (stall_run > 40) begin
                    total++;
                    bad++;
                    $display("FAIL stall_bound: stall_o held %0d cycles, limit 40", stall_run);
                    stall_run = 0;
                end
            end else if (valid_i) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_retire: op 0x%02h retired, no expectation", op_i);
                end else begin
                    it = sb.pop_front();
                    if (it.chk_res) begin
                        chk({it.nm, ".result"}, result_o, it.res);
                        chk({it.nm, ".zero"}, {31'd0, zero_o}, {31'd0, (it.res == 32'd0)});
                    end
                    chk({it.nm, ".ovf"}, {31'd0, overflow_o}, {31'd0, it.ovf});
                    chk({it.nm, ".stalls"}, stall_run, it.stalls);
                    if (it.chk_hl) begin
                        chk({it.nm, ".hi"}, hi_o, it.hi);
                        chk({it.nm, ".lo"}, lo_o, it.lo);
                    end
                end
                stall_run = 0;
            end
            if (end_req) begin
                chk("scoreboard_empty", sb.size(), 0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic run(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sa, input string nm, input bit cr, input logic [31:0] res,
                       input logic ovf, input int st, input bit hl,
                       input logic [31:0] h, input logic [31:0] l);
        item_t it;
        int    n;
        bit    done;
        it.nm = nm; it.chk_res = cr; it.res = res; it.ovf = ovf; it.stalls = st;
        it.chk_hl = hl; it.hi = h; it.lo = l;
        sb.push_back(it);
        valid_i = 1'b1; op_i = op; a_i = a; b_i = b; sa_i = sa;
        n = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge clk);
            done = !stall_o;
            n++;
        end
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic alu(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sa, input string nm, input logic [31:0] res,
                       input logic ovf);
        run(op, a, b, sa, nm, 1'b1, res, ovf, 0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic mfhl(input string nm, input logic [31:0] h, input logic [31:0] l);
        run(OP_MFHI, 32'd0, 32'd0, 5'd0, {nm, ".mfhi"}, 1'b1, h, 1'b0, 0, 1'b1, h, l);
        run(OP_MFLO, 32'd0, 32'd0, 5'd0, {nm, ".mflo"}, 1'b1, l, 1'b0, 0, 1'b1, h, l);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
        op_i = 8'd0; a_i = 32'd0; b_i = 32'd0; sa_i = 5'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        mfhl("reset", 32'd0, 32'd0);
        alu(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0, "add_ovf",  32'h80000000, 1'b1);
        alu(OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0, "addu",     32'h80000000, 1'b0);
        alu(OP_SUB,  32'h80000000, 32'h00000001, 5'd0, "sub_ovf",  32'h7FFFFFFF, 1'b1);
        alu(OP_ADDI, 32'h00000001, 32'hFFFFFFFF, 5'd0, "addi_zero", 32'h00000000, 1'b0);
        alu(OP_SRA,  32'd0,        32'hF0000000, 5'd4, "sra",      32'hFF000000, 1'b0);
        alu(OP_SRL,  32'd0,        32'hF0000000, 5'd4, "srl",      32'h0F000000, 1'b0);
        alu(OP_SLLV, 32'h00000024, 32'h00000001, 5'd0, "sllv",     32'h00000010, 1'b0);
        alu(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0, "slt",      32'h00000001, 1'b0);
        alu(OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 5'd0, "sltu",     32'h00000000, 1'b0);
        alu(OP_ANDI, 32'hFFFFFFFF, 32'hFFFF1234, 5'd0, "andi",     32'h00001234, 1'b0);
        alu(OP_LUI,  32'd0,        32'hABCD1234, 5'd0, "lui",      32'h12340000, 1'b0);
        alu(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0, "and",      32'hF000F000, 1'b0);
        alu(OP_NOR,  32'd0,        32'd0,        5'd0, "nor",      32'hFFFFFFFF, 1'b0);
        alu(OP_LW,   32'h00000100, 32'hFFFFFFFC, 5'd0, "lw_addr",  32'h000000FC, 1'b0);
        alu(OP_BAD,  32'h12345678, 32'h9ABCDEF0, 5'd3, "unknown",  32'h00000000, 1'b0);

        run(OP_MULT, 32'hFFFFFFFD, 32'd7, 5'd0, "mult", 1'b0, 32'd0, 1'b0, MSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);
        run(OP_DIV, 32'hFFFFFFF9, 32'd2, 5'd0, "div", 1'b0, 32'd0, 1'b0, DSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
        run(OP_DIVU, 32'd100, 32'd0, 5'd0, "divu0", 1'b0, 32'd0, 1'b0, DSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("divu0", 32'd100, 32'hFFFFFFFF);
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0, "divmin", 1'b0, 32'd0, 1'b0, DSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("divmin", 32'd0, 32'h80000000);

        alu(OP_MTHI, 32'h12345678, 32'd0, 5'd0, "mthi", 32'h12345678, 1'b0);
        run(OP_MFHI, 32'd0, 32'd0, 5'd0, "mthi.mfhi", 1'b1, 32'h12345678, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        alu(OP_MTLO, 32'hCAFEF00D, 32'd0, 5'd0, "mtlo", 32'hCAFEF00D, 1'b0);
        mfhl("mtlo", 32'h12345678, 32'hCAFEF00D);

        // DIVU killed by flush on its tenth cycle: HI/LO must be untouched.
        valid_i = 1'b1; op_i = OP_DIVU; a_i = 32'd1000; b_i = 32'd3; sa_i = 5'd0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        alu(OP_ADDU, 32'd1, 32'd1, 5'd0, "after_flush", 32'd2, 1'b0);
        mfhl("flush", 32'h12345678, 32'hCAFEF00D);
        run(OP_DIVU, 32'd1000, 32'd3, 5'd0, "divu", 1'b0, 32'd0, 1'b0, DSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("divu", 32'd1, 32'd333);

        // Asynchronous reset in the middle of a MULT.
        valid_i = 1'b1; op_i = OP_MULT; a_i = 32'd5; b_i = 32'd6; sa_i = 5'd0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; valid_i = 1'b0;
        mfhl("rst_mid", 32'd0, 32'd0);

        run(OP_MULTU, 32'hFFFFFFFF, 32'd2, 5'd0, "multu", 1'b0, 32'd0, 1'b0, MSTALL, 1'b0, 32'd0, 32'd0);
        mfhl("multu", 32'd1, 32'hFFFFFFFE);

        end_req = 1'b1;
        repeat (20) @(posedge clk);
        $display("FAIL end_timeout: monitor did not close the run");
        $fatal(1, "end_timeout");
    end

endmodule
